// File: rtl/counter_pkg.sv
// Shared definitions for the counter library (up-counter and down-counter timer).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_pkg;

  // Default counter width shared by the up-counter and the down-counter timer
  localparam int COUNTER_WIDTH = 4;

  // Timer control state
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/down_counter_core.sv
// WIDTH-bit count register with clear, load and decrement, plus an is_one flag.
// Latency: one clk edge from control input to updated count.
// Backpressure: none; the caller decides every edge (clear > load > decrement > hold).
module down_counter_core
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  // Count register: clear wins over load, load wins over decrement, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - WIDTH'(1);
    end
  end

  // Terminal-count detect; the top never decrements past 1, so no wrap is possible
  assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter interval timer: one-shot or auto-reload, pause, abort, done pulse.
// Latency: done rises N edges after the start edge for load N (same edge busy falls in one-shot).
// Backpressure: none; en=0 pauses counting, stop aborts, start retriggers at any time.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             is_one;
  logic             core_clear;
  logic             core_load;
  logic [WIDTH-1:0] core_load_val;
  logic             core_dec;
  logic             terminal;
  logic             load_zero;

  assign load_zero = (load_val == '0);

  // Per-edge priority: stop > start > terminal count > decrement
  always_comb begin
    core_clear    = 1'b0;
    core_load     = 1'b0;
    core_load_val = load_val;
    core_dec      = 1'b0;
    terminal      = 1'b0;
    if (stop) begin
      core_clear = 1'b1;
    end else if (start) begin
      // A zero load is a zero-length interval: count stays at 0
      if (load_zero) core_clear = 1'b1;
      else           core_load  = 1'b1;
    end else if (state == RUN && en) begin
      if (is_one) begin
        terminal = 1'b1;
        if (auto_reload) begin
          core_load     = 1'b1;
          core_load_val = reload;
        end else begin
          core_clear = 1'b1;
        end
      end else begin
        core_dec = 1'b1;
      end
    end
  end

  down_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (core_clear),
    .load     (core_load),
    .load_val (core_load_val),
    .dec      (core_dec),
    .count    (count),
    .is_one   (is_one)
  );

  // FSM with registered busy/done and the reload register; done defaults low every edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      reload <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (start) begin
        if (load_zero) begin
          // Zero-length interval never enters the reload loop
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state  <= RUN;
          busy   <= 1'b1;
          reload <= load_val;
        end
      end else if (terminal) begin
        done <= 1'b1;
        if (!auto_reload) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: a driver issues stimulus and pushes model results,
// a monitor pops and compares on every falling edge.
// Latency: n/a. Backpressure: n/a.
module tb_down_counter_timer;

  localparam int W = 4;

  typedef struct {
    int count;
    bit busy;
    bit done;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         en = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  // Reference model: what the timer should look like after each edge
  int m_count = 0;
  int m_reload = 0;
  bit m_running = 0;
  bit m_done = 0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .en          (en),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_running = 0; m_done = 0;
  endtask

  // Timer rules expressed on integers: stop aborts, start (re)loads, a running enabled
  // timer loses one tick per cycle and when its last tick expires it reports done and
  // either restarts the interval or stops.
  task automatic model_step(input bit st, input bit sp, input bit e, input bit ar, input int lv);
    m_done = 0;
    if (sp) begin
      m_count = 0; m_running = 0;
    end else if (st) begin
      if (lv == 0) begin
        m_count = 0; m_running = 0; m_done = 1;
      end else begin
        m_count = lv; m_reload = lv; m_running = 1;
      end
    end else if (m_running && e) begin
      if (m_count == 1) begin
        m_done = 1;
        if (ar) m_count = m_reload;
        else begin m_count = 0; m_running = 0; end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  // One clock of stimulus: inputs change just after the falling edge
  task automatic drive(input bit st, input bit sp, input bit e, input bit ar, input int lv);
    exp_t x;
    @(negedge clk);
    #1;
    start = st; stop = sp; en = e; auto_reload = ar; load_val = W'(lv);
    model_step(st, sp, e, ar, lv);
    x.count = m_count; x.busy = m_running; x.done = m_done;
    sb_q.push_back(x);
  endtask

  // Monitor: compares DUT outputs to the oldest expectation after each rising edge
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t x;
      x = sb_q.pop_front();
      n_checks++;
      if (int'(count) != x.count || busy !== x.busy || done !== x.done) begin
        n_fail++;
        $display("FAIL scoreboard: got count=%0d busy=%b done=%b, expected count=%0d busy=%b done=%b at t=%0t",
                 count, busy, done, x.count, x.busy, x.done, $time);
      end
    end
  end

  // Measure cycles from the start edge until done, with a bounded wait
  task automatic one_shot_interval(input int lv);
    int seen;
    seen = -1;
    drive(1, 0, 1, 0, lv);
    for (int i = 1; i <= 40; i++) begin
      drive(0, 0, 1, 0, 0);
      if (done === 1'b1) begin
        seen = i - 1;
        break;
      end
    end
    check($sformatf("interval_load%0d", lv), seen, lv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1, 0, 0);
  endtask

  initial begin
    // Asynchronous reset mid-cycle, before any clock edge
    #3 reset = 1'b1;
    #1;
    check("reset_count", int'(count), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    #19 reset = 1'b0;
    model_reset();
    idle(3);

    // One-shot load 5: count 5..0, done with count 0, busy falls with it
    drive(1, 0, 1, 0, 5);
    idle(8);
    one_shot_interval(5);

    // Periodic load 3: 3,2,1,3,2,1 with done every third cycle
    drive(1, 0, 1, 1, 3);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 1, 0);
    drive(0, 1, 1, 1, 0);

    // Pause: load 6, drop en for two cycles at count 4
    drive(1, 0, 1, 0, 6);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    idle(6);

    // Abort at count 2
    drive(1, 0, 1, 0, 4);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    idle(4);

    // start and stop together from IDLE
    drive(1, 1, 1, 0, 7);
    idle(2);

    // Retrigger with 9 while count is 1
    drive(1, 0, 1, 0, 2);
    drive(0, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 9);
    idle(12);

    // Zero load: single done, never busy, even in auto-reload
    drive(1, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0);

    // Maximum load, no wrap
    one_shot_interval(15);
    idle(2);

    // Reset mid-RUN: outputs return to zero immediately
    drive(1, 0, 1, 1, 8);
    idle(3);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrun_reset_count", int'(count), 0);
    check("midrun_reset_busy", int'(busy), 0);
    check("midrun_reset_done", int'(done), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    idle(2);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit st, sp, e, ar;
      int lv;
      st = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 29) == 0);
      e  = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 1);
      lv = $urandom_range(0, 15);
      drive(st, sp, e, ar, lv);
    end

    @(negedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable, parameterised down-counter used as a programmable interval timer.
- Complements the existing free-running up-counter by counting down from a loaded value.
- Signals terminal count with a one-cycle done pulse.
- Supports one-shot and auto-reload (periodic) modes, count enable/pause, and abort.
- Sits beside the up-counter in the counter library; consumed by sequencing logic that needs fixed-length delays or periodic ticks.

Parameters:
- WIDTH, 4, bit width of load value, reload register and count.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request: latch load_val and begin counting.
- stop  input  1  abort the current count, return to IDLE.
- en  input  1  count enable; 0 pauses counting in RUN.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled at each terminal count.
- load_val  input  WIDTH  initial/reload count, sampled when start=1.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle registered pulse at terminal count.

Behaviour:
- Reset (async, active-high): state=IDLE, count=0, reload register=0, busy=0, done=0 immediately, regardless of clk. Release is synchronous to the next clk edge.
- States: IDLE, RUN. busy = (state==RUN), registered.
- done defaults to 0 every cycle. It is high only for the single cycle following a terminal-count edge.
- Priority per edge: stop > start > terminal count > decrement.
- IDLE:
  - start=1, load_val!=0: count<=load_val, reload<=load_val, go RUN.
  - start=1, load_val==0: count<=0, done<=1 next cycle, stay IDLE. Zero-length interval; no reload loop even if auto_reload=1.
  - Otherwise count holds its value.
- RUN, en=1, count>1: count<=count-1.
- RUN, en=1, count==1 (terminal):
  - done<=1.
  - auto_reload=1: count<=reload, stay RUN.
  - auto_reload=0: count<=0, go IDLE; busy falls on the same edge done rises.
- RUN, en=0: count, state and reload all hold; no done.
- start in RUN (retrigger): reload and count take the new load_val, stay RUN, no done, even if count==1 on that edge. load_val==0 behaves as in IDLE: done pulse, go IDLE.
- stop (any state): count<=0, go IDLE, done=0. stop beats a simultaneous start or terminal count.
- Interval: one-shot with load N and en held high gives done exactly N cycles after the start edge. Period in auto-reload mode is N cycles.
- Arithmetic: unsigned, WIDTH bits. Maximum load is 2^WIDTH-1. Count never wraps below 0: the decrement from 1 is always replaced by 0 or reload.
- auto_reload is only sampled at the terminal edge; changing it mid-count has no other effect.

Decomposition:
- Shared package counter_pkg holds:
  - state enum {IDLE, RUN};
  - default WIDTH constant, shared with the up-counter.
- Optional sub-module down_counter_core: WIDTH-bit register with load, decrement, hold and an is_one flag.
- The FSM, priority logic and done generation stay in the top.

Test Plan:
- Reset: assert reset mid-cycle at t=3 -> count=0, busy=0, done=0 immediately (before next edge); hold 20 time units, release -> outputs stay 0 with no start.
- One-shot: load_val=5, start 1 cycle, en=1, auto_reload=0 -> count 5,4,3,2,1,0 on successive edges; done=1 exactly in the cycle count=0; busy 1 -> 0 on that edge; no further done.
- Periodic and pause:
  - load_val=3, auto_reload=1 -> count 3,2,1,3,2,1,... with done every 3rd cycle, busy stays 1.
  - With load_val=6, drop en for 2 cycles at count=4 -> count holds 4, done arrives 2 cycles later (8 cycles after start).
- Abort and priority:
  - stop at count=2 -> count=0, busy=0, done never asserts.
  - start and stop in the same cycle from IDLE -> stays IDLE, count=0.
- Retrigger and boundaries:
  - start with load_val=9 while count=1 -> count=9, no done.
  - load_val=0 start -> single done pulse, busy stays 0.
  - load_val=15 (WIDTH=4) -> done 15 cycles later, no wrap.
  - Reset asserted mid-RUN -> immediate return to 0/IDLE.
